// File: rtl/video_timing_monitor.sv
// video_timing_monitor: measures the line and frame timing of a tpg
// hs/vs/vld/rgb stream, checksums active pixels, and compares the results
// against programmed expected values at every frame boundary.
module video_timing_monitor #(
   parameter int unsigned PW      = 8,
   parameter int unsigned H_BITS  = 12,
   parameter int unsigned V_BITS  = 12,
   parameter int unsigned CS_BITS = 32
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                hs,
   input  logic                vs,
   input  logic                vld,
   input  logic [3*PW-1:0]     rgb,
   input  logic [H_BITS-1:0]   exp_htotal,
   input  logic [H_BITS-1:0]   exp_hact,
   input  logic [V_BITS-1:0]   exp_vtotal,
   input  logic [V_BITS-1:0]   exp_vact,
   input  logic                clr_err,
   output logic [H_BITS-1:0]   meas_htotal_q,
   output logic [H_BITS-1:0]   meas_hact_q,
   output logic [V_BITS-1:0]   meas_vtotal_q,
   output logic [V_BITS-1:0]   meas_vact_q,
   output logic [CS_BITS-1:0]  checksum_q,
   output logic                frame_done_q,
   output logic                locked_q,
   output logic [4:0]          err_q
);

   typedef enum logic {ST_SEARCH = 1'b0, ST_RUN = 1'b1} state_t;

   state_t              r_state, w_state_nxt;
   logic                r_hs_d, r_vs_d;
   logic                w_hs_rise, w_vs_rise;

   logic [H_BITS-1:0]   r_cyc, r_pix, r_ref_htotal, r_first_hact, r_last_hact;
   logic [V_BITS-1:0]   r_lines, r_act_lines;
   logic [CS_BITS-1:0]  r_checksum;
   logic                r_ref_valid, r_seen_hs, r_frame_err;

   logic [H_BITS-1:0]   w_cyc_nxt, w_pix_nxt, w_ref_htotal_nxt, w_first_hact_nxt, w_last_hact_nxt;
   logic [V_BITS-1:0]   w_lines_nxt, w_act_lines_nxt;
   logic [CS_BITS-1:0]  w_checksum_nxt;
   logic                w_ref_valid_nxt, w_seen_hs_nxt, w_frame_err_nxt;
   logic [H_BITS-1:0]   w_period;

   logic [H_BITS-1:0]   w_meas_htotal_nxt, w_meas_hact_nxt;
   logic [V_BITS-1:0]   w_meas_vtotal_nxt, w_meas_vact_nxt;
   logic [CS_BITS-1:0]  w_cs_pub_nxt;
   logic                w_frame_done_nxt, w_locked_nxt;
   logic [4:0]          w_err_set, w_err_nxt;
   logic                w_mis_ht, w_mis_ha, w_mis_vt, w_mis_va;

   function automatic logic [H_BITS-1:0] inc_h(input logic [H_BITS-1:0] x);
      return (x == '1) ? x : x + 1'b1;
   endfunction

   function automatic logic [V_BITS-1:0] inc_v(input logic [V_BITS-1:0] x);
      return (x == '1) ? x : x + 1'b1;
   endfunction

   assign w_hs_rise = hs & ~r_hs_d;
   assign w_vs_rise = vs & ~r_vs_d;
   assign w_period  = inc_h(r_cyc);

   // Next-state, frame accumulation and publication logic.
   // Order inside RUN: close the open line on either edge (old pix), then
   // publish and clear on vs, then apply hs and vld to the (possibly new)
   // frame. A coincident hs therefore lands as line 1 with no period.
   always_comb begin
      w_state_nxt       = r_state;
      w_cyc_nxt         = r_cyc;
      w_pix_nxt         = r_pix;
      w_ref_htotal_nxt  = r_ref_htotal;
      w_first_hact_nxt  = r_first_hact;
      w_last_hact_nxt   = r_last_hact;
      w_lines_nxt       = r_lines;
      w_act_lines_nxt   = r_act_lines;
      w_checksum_nxt    = r_checksum;
      w_ref_valid_nxt   = r_ref_valid;
      w_seen_hs_nxt     = r_seen_hs;
      w_frame_err_nxt   = r_frame_err;
      w_meas_htotal_nxt = meas_htotal_q;
      w_meas_hact_nxt   = meas_hact_q;
      w_meas_vtotal_nxt = meas_vtotal_q;
      w_meas_vact_nxt   = meas_vact_q;
      w_cs_pub_nxt      = checksum_q;
      w_frame_done_nxt  = 1'b0;
      w_locked_nxt      = locked_q;
      w_err_set         = '0;
      w_mis_ht          = 1'b0;
      w_mis_ha          = 1'b0;
      w_mis_vt          = 1'b0;
      w_mis_va          = 1'b0;

      case (r_state)
         ST_SEARCH: begin
            if (w_vs_rise) begin
               w_cyc_nxt        = '0;
               w_pix_nxt        = '0;
               w_ref_htotal_nxt = '0;
               w_first_hact_nxt = '0;
               w_last_hact_nxt  = '0;
               w_lines_nxt      = '0;
               w_act_lines_nxt  = '0;
               w_checksum_nxt   = '0;
               w_ref_valid_nxt  = 1'b0;
               w_seen_hs_nxt    = 1'b0;
               w_frame_err_nxt  = 1'b0;
               w_state_nxt      = ST_RUN;
            end
         end
         ST_RUN: begin
            w_cyc_nxt = inc_h(r_cyc);

            if (w_hs_rise || w_vs_rise) begin
               if (r_pix != '0) begin
                  w_act_lines_nxt = inc_v(r_act_lines);
                  w_last_hact_nxt = r_pix;
                  if (r_act_lines == '0) begin
                     w_first_hact_nxt = r_pix;
                  end else if (r_pix != r_first_hact) begin
                     w_err_set[1]    = 1'b1;
                     w_frame_err_nxt = 1'b1;
                  end
               end
               w_pix_nxt = '0;
            end

            if (w_vs_rise) begin
               w_meas_htotal_nxt = r_ref_htotal;
               w_meas_hact_nxt   = w_last_hact_nxt;
               w_meas_vtotal_nxt = r_lines;
               w_meas_vact_nxt   = w_act_lines_nxt;
               w_cs_pub_nxt      = r_checksum;
               w_frame_done_nxt  = 1'b1;
               w_mis_ht          = (r_ref_htotal != exp_htotal);
               w_mis_ha          = (w_last_hact_nxt != exp_hact);
               w_mis_vt          = (r_lines != exp_vtotal);
               w_mis_va          = (w_act_lines_nxt != exp_vact);
               w_err_set[0]      = w_mis_ht;
               w_err_set[1]      = w_err_set[1] | w_mis_ha;
               w_err_set[2]      = w_mis_vt;
               w_err_set[3]      = w_mis_va;
               w_locked_nxt      = ~(w_mis_ht | w_mis_ha | w_mis_vt | w_mis_va | w_frame_err_nxt);
               w_cyc_nxt         = '0;
               w_ref_htotal_nxt  = '0;
               w_first_hact_nxt  = '0;
               w_last_hact_nxt   = '0;
               w_lines_nxt       = '0;
               w_act_lines_nxt   = '0;
               w_checksum_nxt    = '0;
               w_ref_valid_nxt   = 1'b0;
               w_seen_hs_nxt     = 1'b0;
               w_frame_err_nxt   = 1'b0;
            end

            if (w_hs_rise) begin
               if (w_seen_hs_nxt) begin
                  if (!w_ref_valid_nxt) begin
                     w_ref_htotal_nxt = w_period;
                     w_ref_valid_nxt  = 1'b1;
                  end else if (w_period != w_ref_htotal_nxt) begin
                     w_err_set[4]    = 1'b1;
                     w_frame_err_nxt = 1'b1;
                  end
               end
               w_seen_hs_nxt = 1'b1;
               w_cyc_nxt     = '0;
               w_lines_nxt   = inc_v(w_lines_nxt);
            end

            if (vld) begin
               w_pix_nxt      = inc_h(w_pix_nxt);
               w_checksum_nxt = w_checksum_nxt + CS_BITS'(rgb);
            end
         end
         default: w_state_nxt = ST_SEARCH;
      endcase

      w_err_nxt = (clr_err ? 5'b0 : err_q) | w_err_set;
   end

   // State register plus all accumulators and published results.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state       <= ST_SEARCH;
         r_hs_d        <= 1'b0;
         r_vs_d        <= 1'b0;
         r_cyc         <= '0;
         r_pix         <= '0;
         r_ref_htotal  <= '0;
         r_first_hact  <= '0;
         r_last_hact   <= '0;
         r_lines       <= '0;
         r_act_lines   <= '0;
         r_checksum    <= '0;
         r_ref_valid   <= 1'b0;
         r_seen_hs     <= 1'b0;
         r_frame_err   <= 1'b0;
         meas_htotal_q <= '0;
         meas_hact_q   <= '0;
         meas_vtotal_q <= '0;
         meas_vact_q   <= '0;
         checksum_q    <= '0;
         frame_done_q  <= 1'b0;
         locked_q      <= 1'b0;
         err_q         <= '0;
      end else begin
         r_state       <= w_state_nxt;
         r_hs_d        <= hs;
         r_vs_d        <= vs;
         r_cyc         <= w_cyc_nxt;
         r_pix         <= w_pix_nxt;
         r_ref_htotal  <= w_ref_htotal_nxt;
         r_first_hact  <= w_first_hact_nxt;
         r_last_hact   <= w_last_hact_nxt;
         r_lines       <= w_lines_nxt;
         r_act_lines   <= w_act_lines_nxt;
         r_checksum    <= w_checksum_nxt;
         r_ref_valid   <= w_ref_valid_nxt;
         r_seen_hs     <= w_seen_hs_nxt;
         r_frame_err   <= w_frame_err_nxt;
         meas_htotal_q <= w_meas_htotal_nxt;
         meas_hact_q   <= w_meas_hact_nxt;
         meas_vtotal_q <= w_meas_vtotal_nxt;
         meas_vact_q   <= w_meas_vact_nxt;
         checksum_q    <= w_cs_pub_nxt;
         frame_done_q  <= w_frame_done_nxt;
         locked_q      <= w_locked_nxt;
         err_q         <= w_err_nxt;
      end
   end

endmodule

// File: doc/video_timing_monitor.md
Name: video_timing_monitor

Overview:
- Sits directly downstream of the test pattern generator (tpg) and consumes its hs/vs/vld/rgb stream.
- Measures per-frame line period, active pixels per line, lines per frame and active lines per frame.
- Accumulates a checksum of active pixels and compares the measurements against programmed expected values.
- Reports sticky error flags and lock status, giving the bench a self-checking sink for tpg output.

Parameters:
PW, 8, bits per colour component; rgb is 3*PW wide
H_BITS, 12, width of horizontal counters/expected values
V_BITS, 12, width of vertical counters/expected values
CS_BITS, 32, checksum width

Ports:
clk  in  1  single clock, all logic rising-edge
rst_n  in  1  asynchronous active-low reset
hs  in  1  horizontal sync, active high (tpg hs_q)
vs  in  1  vertical sync, active high (tpg vs_q)
vld  in  1  active-pixel qualifier (tpg vld_q)
rgb  in  3*PW  pixel data, meaningful only when vld=1
exp_htotal  in  H_BITS  expected clocks per line
exp_hact  in  H_BITS  expected vld cycles per active line
exp_vtotal  in  V_BITS  expected lines per frame
exp_vact  in  V_BITS  expected active lines per frame
clr_err  in  1  clears err_q (level, synchronous)
meas_htotal_q  out  H_BITS  measured line period, last frame
meas_hact_q  out  H_BITS  vld count of last active line, last frame
meas_vtotal_q  out  V_BITS  hs rises in last frame
meas_vact_q  out  V_BITS  lines with >=1 vld in last frame
checksum_q  out  CS_BITS  sum of active rgb, last frame
frame_done_q  out  1  one-cycle pulse when results are published
locked_q  out  1  last published frame matched all expected values
err_q  out  5  sticky error flags

Behaviour:
- Reset: all outputs 0, FSM in SEARCH, internal counters 0, hs/vs history registers 0.
- Edge detection: hs_d/vs_d register the previous inputs; hs_rise = hs & ~hs_d and vs_rise = vs & ~vs_d, both combinational from the current input.
- FSM SEARCH:
  - All pixel and line activity is ignored.
  - On vs_rise: clear frame accumulators, go to RUN. Nothing is published.
- FSM RUN, per cycle:
  - cyc increments, saturating at all-ones.
  - On hs_rise:
    - If a previous hs_rise exists in this frame, line period = cyc+1. The first measured period in a frame is held as ref_htotal; a later period != ref_htotal sets err_q[4].
    - Then cyc=0 and lines++ (saturating).
    - If the line just closed had pix>0: act_lines++ and last_hact=pix. A second active line with a pix count different from the first active line's sets err_q[1].
    - pix=0.
  - vld=1: pix++ (saturating), checksum += zero-extended rgb, mod 2^CS_BITS.
- Publication: on vs_rise while in RUN:
  - The open line is closed first, using the same rules as an hs_rise close.
  - Registered values load: meas_htotal_q=ref_htotal, meas_hact_q=last_hact, meas_vtotal_q=lines, meas_vact_q=act_lines, checksum_q=checksum.
  - frame_done_q=1 for exactly one cycle, visible the cycle after the vs_rise edge.
  - Compares:
    - err_q[0] on htotal != exp_htotal.
    - err_q[1] also on hact != exp_hact.
    - err_q[2] on vtotal != exp_vtotal.
    - err_q[3] on vact != exp_vact.
    - locked_q=1 only if all four match and no err_q[4]/[1] was raised during this frame; otherwise 0.
  - Accumulators clear.
- Simultaneous hs_rise and vs_rise: the frame is closed and published first; the hs_rise then counts as line 1 of the new frame (lines=1 after that edge, with no period measured).
- Errors: err_q bits are sticky. clr_err=1 clears them, but a new error raised in the same cycle wins (set priority). locked_q is unaffected by clr_err.
- Reset mid-frame: immediate return to SEARCH; published values and flags are zeroed and the partial frame is discarded.
- Saturated counters hold all-ones; a saturated measurement mismatches any smaller expected value.
- Latency: measurement to output is one cycle. No backpressure; the block never stalls its source.

Test Plan:
- Reset then drive 3 frames (htotal 61, hs width 10, 11 vld per line on 11 lines, 41 lines, rgb=0x000001), expected values programmed to match → first frame_done_q after the 2nd vs rise; meas = 61/11/41/11; checksum_q=121; locked_q=1; err_q=0.
- Same stream with exp_vtotal=40 → err_q[2]=1, locked_q=0; assert clr_err for 1 cycle → err_q=0, and err_q[2] sets again at the next frame_done_q.
- One line in a frame stretched to 62 clocks → err_q[4]=1 and locked_q=0 for that frame; the following clean frame gives locked_q=1 with err_q[4] still set.
- hs_rise coincident with vs_rise → published meas_vtotal_q unchanged (41); the next frame also reports 41.
- rst_n pulsed low for 30 time units mid-frame → all outputs 0 asynchronously; the first frame_done_q occurs only after two further vs rises.
- rgb=0xFFFFFF on every active pixel with CS_BITS=16 → checksum_q = (121*0xFFFFFF) mod 2^16 = 0xFF87.
